cntr_uart_tx: RTL and testbench

- Serial transmit end for the counter design: accepts a count byte over a valid/ready handshake and shifts it out as a UART 8N1 frame on one pin.
- Sits between the counter core and a uio_out bit in the tt_um_ryl19_cntr_top wrapper.
- Lets an external host receiver read the counter value without a parallel bus.

---
 rtl/cntr_uart_tx.sv | 117 +++++++++++
 tb/tb_cntr_uart_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cntr_uart_tx.sv
// rtl/cntr_uart_tx.sv - UART 8N1 transmitter taking a count byte over valid/ready
module cntr_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [DIV_W-1:0]     div, div_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 tx_n;
  logic                 in_ready_n;
  logic                 bit_end;

  assign bit_end = (div == DIV_LAST);

  // tx is registered, so its next value is chosen here alongside the state change
  always_comb begin
    state_n    = state;
    div_n      = div;
    idx_n      = idx;
    shift_n    = shift;
    tx_n       = tx;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (in_valid && in_ready) begin
          state_n = START;
          div_n   = '0;
          shift_n = in_data;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          div_n   = '0;
          idx_n   = '0;
          tx_n    = shift[0];
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          div_n   = '0;
          shift_n = shift >> 1;
          if (idx == IDX_LAST) begin
            state_n = STOP;
            idx_n   = '0;
            tx_n    = 1'b1;
          end else begin
            idx_n = idx + IDX_W'(1);
            tx_n  = shift[1];
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      STOP: begin
        frame_done = bit_end;
        tx_n       = 1'b1;
        if (bit_end) begin
          state_n = IDLE;
          div_n   = '0;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        div_n   = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
    in_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      idx      <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      div      <= div_n;
      idx      <= idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
      in_ready <= in_ready_n;
      busy     <= ~in_ready_n;
    end
  end

endmodule

// File: tb/tb_cntr_uart_tx.sv
// tb/tb_cntr_uart_tx.sv - randomized bench for cntr_uart_tx against a frame waveform model
module tb_cntr_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data_a  [3];
  logic       in_valid_a [3];
  logic       in_ready_a [3];
  logic       tx_a       [3];
  logic       busy_a     [3];
  logic       fd_a       [3];

  int n_cmp = 0;
  int n_bad = 0;
  int last_wait;

  always #5 clk = ~clk;

  cntr_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data_a[0]), .in_valid(in_valid_a[0]),
    .in_ready(in_ready_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .frame_done(fd_a[0]));

  cntr_uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data_a[1][4:0]), .in_valid(in_valid_a[1]),
    .in_ready(in_ready_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .frame_done(fd_a[1]));

  cntr_uart_tx #(.CLKS_PER_BIT(104), .DATA_BITS(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data_a[2]), .in_valid(in_valid_a[2]),
    .in_ready(in_ready_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .frame_done(fd_a[2]));

  function automatic int cpb_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 2 : 104;
  endfunction

  function automatic int db_of(input int s);
    return (s == 1) ? 5 : 8;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int s, input string tag);
    check($sformatf("%s_s%0d_tx", tag, s), 32'(tx_a[s]), 1);
    check($sformatf("%s_s%0d_ready", tag, s), 32'(in_ready_a[s]), 1);
    check($sformatf("%s_s%0d_busy", tag, s), 32'(busy_a[s]), 0);
    check($sformatf("%s_s%0d_fd", tag, s), 32'(fd_a[s]), 0);
  endtask

  // Entered and left at a falling edge. Expected line level for frame cycle k
  // comes from which bit slot k falls into: start, data LSB first, then stop.
  task automatic send_frame(input int s, input logic [7:0] b, input logic [7:0] mid, input bit hold);
    int cpb, db, n, waited, slot, fd_cycle, fd_count;
    logic [7:0] dec, mask;
    logic exp_lvl;
    cpb = cpb_of(s);
    db = db_of(s);
    n = (db + 2) * cpb;
    mask = 8'((1 << db) - 1);
    waited = 0;
    while (in_ready_a[s] !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("s%0d_ready_wait", s), 32'(in_ready_a[s]), 1);
    last_wait = waited;
    in_data_a[s] = b;
    in_valid_a[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid_a[s] = 1'b0;
    in_data_a[s] = mid;
    dec = 8'h00;
    fd_cycle = 0;
    fd_count = 0;
    for (int k = 1; k <= n; k++) begin
      slot = (k - 1) / cpb;
      if (slot == 0) exp_lvl = 1'b0;
      else if (slot <= db) exp_lvl = b[slot-1];
      else exp_lvl = 1'b1;
      check($sformatf("s%0d_tx_k%0d", s, k), 32'(tx_a[s]), 32'(exp_lvl));
      check($sformatf("s%0d_busy_k%0d", s, k), 32'(busy_a[s]), 1);
      check($sformatf("s%0d_ready_k%0d", s, k), 32'(in_ready_a[s]), 0);
      if (fd_a[s] === 1'b1) begin
        fd_count++;
        fd_cycle = k;
      end
      if (slot >= 1 && slot <= db && ((k - 1) % cpb) == cpb / 2) dec[slot-1] = tx_a[s];
      @(negedge clk);
    end
    check($sformatf("s%0d_fd_count", s), 32'(fd_count), 1);
    check($sformatf("s%0d_frame_len", s), 32'(fd_cycle), 32'(n));
    check($sformatf("s%0d_decoded", s), 32'(dec), 32'(b & mask));
    check_idle(s, "post");
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      in_valid_a[s] = 1'b1;
      in_data_a[s] = 8'hA5;
    end
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) check_idle(s, "reset");
    end
    rst = 1'b0;
    for (int s = 0; s < 3; s++) in_valid_a[s] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) check_idle(s, "after_reset");

    send_frame(0, 8'hA5, 8'h5A, 1'b0);

    send_frame(0, 8'h00, 8'h00, 1'b1);
    send_frame(0, 8'hFF, 8'hFF, 1'b0);
    check("b2b_gap", 32'(last_wait), 0);

    send_frame(0, 8'hC3, 8'h3C, 1'b0);

    // abort a frame during data bit 3 (frame cycles 17..20 at 4 clocks per bit)
    in_data_a[0] = 8'hC3;
    in_valid_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_bit3_tx", 32'(tx_a[0]), 0);
    check("mid_busy", 32'(busy_a[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx", 32'(tx_a[0]), 1);
    check("abort_ready", 32'(in_ready_a[0]), 1);
    check("abort_busy", 32'(busy_a[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(0, 8'h5A, 8'($urandom), 1'b0);

    repeat (64) send_frame(0, 8'($urandom), 8'($urandom), 1'($urandom));
    in_valid_a[0] = 1'b0;
    @(negedge clk);
    repeat (256) send_frame(1, 8'($urandom), 8'($urandom), 1'($urandom));
    in_valid_a[1] = 1'b0;
    @(negedge clk);
    repeat (40) send_frame(2, 8'($urandom), 8'($urandom), 1'($urandom));
    in_valid_a[2] = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
